// File: rtl/tone_divider.sv
// ============================================================================
// Module   : tone_divider
// Purpose  : Unsigned restoring divider, one quotient bit per clock, MSB first.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tone_divider #(
    parameter int n = 22
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [n-1:0] dividend,
    input  logic [n-1:0] divisor,
    output logic         busy,
    output logic         done,
    output logic [n-1:0] quotient,
    output logic [n-1:0] remainder,
    output logic         div_zero
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int              CW          = $clog2(n + 1);
    localparam logic [CW-1:0]   c_last_iter = CW'(n - 1);

    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [n-1:0]   dvd_q, dvd_d;
    logic [n-1:0]   dvs_q, dvs_d;
    logic [n-1:0]   part_q, part_d;
    logic [n-1:0]   quo_q, quo_d;
    logic [n-1:0]   quotient_q, quotient_d;
    logic [n-1:0]   remainder_q, remainder_d;
    logic           div_zero_q, div_zero_d;

    logic [n:0]     w_trial;
    logic           w_fits;
    logic [n-1:0]   w_part_next;
    logic [n-1:0]   w_quo_next;

    // One restoring step: the trial value needs n+1 bits, but after the
    // conditional subtract it is always below the divisor and fits in n bits.
    always_comb begin
        w_trial     = {part_q, dvd_q[n-1]};
        w_fits      = (w_trial >= {1'b0, dvs_q});
        w_part_next = w_fits ? n'(w_trial - {1'b0, dvs_q}) : w_trial[n-1:0];
        w_quo_next  = {quo_q[n-2:0], w_fits};
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        dvd_d       = dvd_q;
        dvs_d       = dvs_q;
        part_d      = part_q;
        quo_d       = quo_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        div_zero_d  = div_zero_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    dvd_d  = dividend;
                    dvs_d  = divisor;
                    cnt_d  = '0;
                    part_d = '0;
                    quo_d  = '0;
                    if (divisor == '0) begin
                        quotient_d  = '1;
                        remainder_d = dividend;
                        div_zero_d  = 1'b1;
                        state_d     = DONE;
                    end else begin
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                part_d = w_part_next;
                quo_d  = w_quo_next;
                dvd_d  = {dvd_q[n-2:0], 1'b0};
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == c_last_iter) begin
                    quotient_d  = w_quo_next;
                    remainder_d = w_part_next;
                    div_zero_d  = 1'b0;
                    state_d     = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            dvd_q       <= '0;
            dvs_q       <= '0;
            part_q      <= '0;
            quo_q       <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            div_zero_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            dvd_q       <= dvd_d;
            dvs_q       <= dvs_d;
            part_q      <= part_d;
            quo_q       <= quo_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            div_zero_q  <= div_zero_d;
        end
    end

    assign busy      = (state_q == RUN);
    assign done      = (state_q == DONE);
    assign quotient  = quotient_q;
    assign remainder = remainder_q;
    assign div_zero  = div_zero_q;

endmodule

`default_nettype wire

// File: doc/tone_divider.md
TONE_DIVIDER -- requirements
Module: tone_divider

Interface
REQ-001 SHALL have parameter n, default 22, operand/result width in bits.
REQ-002 SHALL have port clk, input, 1, system clock; all state updates on rising edge.
REQ-003 SHALL have port rst, input, 1, reset; one clock; reset is synchronous and active-high.
REQ-004 SHALL have port start, input, 1, request a division; sampled only in IDLE.
REQ-005 SHALL have port dividend, input, n, unsigned numerator (e.g. clock count per second); captured on accepted start.
REQ-006 SHALL have port divisor, input, n, unsigned denominator (e.g. tone frequency); captured on accepted start.
REQ-007 SHALL have port busy, output, 1, high while a division is in progress (RUN state).
REQ-008 SHALL have port done, output, 1, one-cycle pulse marking results valid.
REQ-009 SHALL have port quotient, output, n, unsigned quotient.
REQ-010 SHALL have port remainder, output, n, unsigned remainder.
REQ-011 SHALL have port div_zero, output, 1, set when the last accepted divisor was zero.

Function
REQ-012 SHALL implement restoring division by iterated subtraction, one quotient bit per clock, MSB first.
REQ-013 SHALL use states IDLE, RUN, DONE; IDLE->RUN on start with divisor!=0; IDLE->DONE on start with divisor==0; RUN->DONE after exactly n iterations; DONE->IDLE unconditionally next cycle.
REQ-014 SHALL, on an accepted start at edge k, capture operands, clear iteration count, and assert busy from edge k.
REQ-015 SHALL perform iterations at edges k+1..k+n; each: partial remainder (n+1 bits) = {partial[n-1:0], next dividend bit}; if partial >= divisor, subtract divisor and shift in quotient bit 1, else shift in 0.
REQ-016 SHALL enter DONE at edge k+n: busy low, done high for exactly one cycle, quotient/remainder updated at that edge.
REQ-017 SHALL hold quotient, remainder, div_zero stable from DONE until the next accepted start completes or reset.
REQ-018 SHALL ignore start while in RUN or DONE; captured operands SHALL be unaffected by input changes after acceptance.
REQ-019 SHALL, for divisor==0, enter DONE at edge k with quotient = all ones, remainder = dividend, div_zero=1; done pulses in cycle following edge k (latency 1).
REQ-020 SHALL clear div_zero at the DONE of any division with nonzero divisor.
REQ-021 SHALL guarantee remainder < divisor and quotient*divisor + remainder == dividend for every nonzero divisor, including dividend=0 and dividend < divisor.
REQ-022 SHALL accept start in the IDLE cycle immediately after DONE (back-to-back throughput n+2 cycles per result).

Reset
REQ-023 SHALL, with rst high at a rising edge, enter IDLE and drive busy=0, done=0, div_zero=0, quotient=0, remainder=0, clearing internal count and partial remainder.
REQ-024 SHALL abort any division in progress on reset with no done pulse; rst SHALL take priority over start in the same cycle.
REQ-025 SHALL accept a start in the first cycle after rst deasserts.

Verification
REQ-026 SHALL verify dividend=1000000, divisor=440 -> done exactly n cycles after start edge, quotient=2272, remainder=320, div_zero=0.
REQ-027 SHALL verify dividend=5, divisor=0 -> done one cycle after start, quotient=0x3FFFFF, remainder=5, div_zero=1; then 7/7 -> quotient=1, remainder=0, div_zero=0.
REQ-028 SHALL verify boundaries: 3/10 -> 0 r3; 0/9 -> 0 r0; 4194303/1 -> 4194303 r0; 4194303/4194303 -> 1 r0.
REQ-029 SHALL verify start pulsed during RUN with different operands -> ignored; result matches first operands; single done pulse.
REQ-030 SHALL verify rst asserted mid-RUN (iteration 10) -> next cycle busy=0, done=0, outputs 0; fresh start 100/7 -> 14 r2.
REQ-031 SHALL verify back-to-back starts at each IDLE for 1000 random operand pairs against a reference model, checking latency n and busy/done never both high.
